// File: rtl/signal_debounce.sv
// Raw-input conditioner: synchroniser, run-length qualifier that rejects short
// pulses, registered rise/fall pulses and a saturating glitch counter.
module signal_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw_in,
  input  logic                enable,
  input  logic                clr_glitch,
  output logic                signal_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic [GLITCH_W-1:0]    r_glitch;

  logic w_s;
  logic w_differs;
  logic w_glitch;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_s != r_level);
  // A reverted sample while pending is a rejected transition.
  assign w_glitch  = enable && (r_state == ST_PENDING) && !w_differs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (!enable) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_STABLE: begin
            if (!w_differs) begin
              r_cnt <= '0;
            end else if (STABLE_CYCLES == 1) begin
              r_level <= w_s;
              r_rise  <= w_s;
              r_fall  <= ~w_s;
            end else begin
              r_state <= ST_PENDING;
              r_cnt   <= CNT_W'(1);
            end
          end
          ST_PENDING: begin
            if (!w_differs) begin
              r_state <= ST_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_level <= w_s;
              r_rise  <= w_s;
              r_fall  <= ~w_s;
              r_state <= ST_STABLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Clear has priority over a coincident glitch; the count saturates.
  always_ff @(posedge clk) begin
    if (reset || clr_glitch) begin
      r_glitch <= '0;
    end else if (w_glitch && (r_glitch != {GLITCH_W{1'b1}})) begin
      r_glitch <= r_glitch + 1'b1;
    end
  end

  assign signal_out   = r_level;
  assign rise_pulse   = r_rise;
  assign fall_pulse   = r_fall;
  assign glitch_count = r_glitch;

endmodule

// File: tb/tb_signal_debounce.sv
// Scoreboarded random/directed bench for signal_debounce; three configurations
// share one stimulus stream and one run-length reference model.
module tb_signal_debounce;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw_in = 1'b0;
  logic enable = 1'b1;
  logic clr_glitch = 1'b0;

  logic       o0, r0, f0;
  logic [7:0] gc0;
  logic       o1, r1, f1;
  logic [1:0] gc1;
  logic       o2, r2, f2;
  logic [3:0] gc2;

  always #5 clk = ~clk;

  signal_debounce u0 (
    .clk(clk), .reset(reset), .raw_in(raw_in), .enable(enable), .clr_glitch(clr_glitch),
    .signal_out(o0), .rise_pulse(r0), .fall_pulse(f0), .glitch_count(gc0)
  );

  signal_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(2)) u1 (
    .clk(clk), .reset(reset), .raw_in(raw_in), .enable(enable), .clr_glitch(clr_glitch),
    .signal_out(o1), .rise_pulse(r1), .fall_pulse(f1), .glitch_count(gc1)
  );

  signal_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(1), .GLITCH_W(4)) u2 (
    .clk(clk), .reset(reset), .raw_in(raw_in), .enable(enable), .clr_glitch(clr_glitch),
    .signal_out(o2), .rise_pulse(r2), .fall_pulse(f2), .glitch_count(gc2)
  );

  logic [95:0] act;
  assign act = {16'd0, {4'd0, gc2}, 5'd0, f2, r2, o2,
                16'd0, {6'd0, gc1}, 5'd0, f1, r1, o1,
                16'd0, gc0,         5'd0, f0, r0, o0};

  function automatic int sync_n(input int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic int stab(input int i);
    return (i == 2) ? 1 : 4;
  endfunction
  function automatic int gmax(input int i);
    case (i)
      0:       return 255;
      1:       return 3;
      default: return 15;
    endcase
  endfunction

  // Reference model: delay line for the synchroniser, then run-length rules.
  logic pipe [3][4];
  logic m_out [3];
  int   m_run [3];
  int   m_gc  [3];
  logic [95:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;

  task automatic step(input logic rst, input logic rw, input logic en, input logic cl);
    logic [95:0] e;
    logic s, rise, fall, gl;
    @(negedge clk);
    reset = rst; raw_in = rw; enable = en; clr_glitch = cl;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      rise = 1'b0; fall = 1'b0; gl = 1'b0;
      if (rst) begin
        for (int k = 0; k < 4; k++) pipe[i][k] = 1'b0;
        m_out[i] = 1'b0; m_run[i] = 0; m_gc[i] = 0;
      end else begin
        s = pipe[i][sync_n(i)-1];
        for (int k = 3; k > 0; k--) pipe[i][k] = pipe[i][k-1];
        pipe[i][0] = rw;
        if (!en) begin
          m_run[i] = 0;
        end else if (s != m_out[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == stab(i)) begin
            m_out[i] = s; rise = s; fall = !s; m_run[i] = 0;
          end
        end else begin
          gl = (m_run[i] > 0);
          m_run[i] = 0;
        end
        if (cl) m_gc[i] = 0;
        else if (gl && m_gc[i] < gmax(i)) m_gc[i] = m_gc[i] + 1;
      end
      e[32*i]      = m_out[i];
      e[32*i+1]    = rise;
      e[32*i+2]    = fall;
      e[32*i+8 +: 8] = 8'(m_gc[i]);
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input int n, input logic rw, input logic en, input logic cl);
    for (int k = 0; k < n; k++) step(1'b0, rw, en, cl);
  endtask

  function automatic void cmp(input string name, input int inst, input int a, input int x);
    n_vec++;
    if (a != x) begin
      n_err++;
      $display("FAIL %s u%0d cycle %0d: got %0d expected %0d", name, inst, n_cyc, a, x);
    end
  endfunction

  // Monitor: every edge the DUTs present a fresh output set.
  initial begin
    logic [95:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cyc++;
        for (int i = 0; i < 3; i++) begin
          cmp("signal_out",   i, int'(act[32*i]),        int'(e[32*i]));
          cmp("rise_pulse",   i, int'(act[32*i+1]),      int'(e[32*i+1]));
          cmp("fall_pulse",   i, int'(act[32*i+2]),      int'(e[32*i+2]));
          cmp("glitch_count", i, int'(act[32*i+8 +: 8]), int'(e[32*i+8 +: 8]));
          cmp("pulse_excl",   i, int'(act[32*i+1] & act[32*i+2]), 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lvl;
    int len;
    logic en_r;
    // Reset, then a clean rise held 10 cycles and a fall.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    hold(10, 1'b1, 1'b1, 1'b0);
    hold(10, 1'b0, 1'b1, 1'b0);
    // Two-cycle glitch from idle.
    hold(2, 1'b1, 1'b1, 1'b0);
    hold(8, 1'b0, 1'b1, 1'b0);
    // Three clean 6-high / 6-low pulses.
    repeat (3) begin
      hold(6, 1'b1, 1'b1, 1'b0);
      hold(6, 1'b0, 1'b1, 1'b0);
    end
    hold(4, 1'b0, 1'b1, 1'b0);
    // Five 1-cycle glitches, then a sixth whose counting edge sees clr.
    repeat (5) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      hold(5, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    hold(2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    hold(4, 1'b0, 1'b1, 1'b0);
    // Disabled while raw toggles, then re-enable with raw high.
    for (int k = 0; k < 20; k++) step(1'b0, 1'(k % 2), 1'b0, 1'b0);
    hold(10, 1'b1, 1'b1, 1'b0);
    // Reset with the qualifier pending at cnt=2, raw kept high afterwards.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    hold(4, 1'b0, 1'b1, 1'b0);
    hold(4, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    hold(10, 1'b1, 1'b1, 1'b0);
    // Randomised runs of mixed lengths with occasional disable/clear/reset.
    lvl = 1'b0;
    for (int r = 0; r < 300; r++) begin
      lvl  = ~lvl;
      len  = $urandom_range(1, 8);
      en_r = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < len; k++)
        step(($urandom_range(0, 199) == 0), lvl, en_r, ($urandom_range(0, 29) == 0));
    end
    hold(3, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
